// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG run-length / size-category encoder.
package jpeg_pkg;

  localparam int DEF_COEF_W = 12;
  localparam int DEF_SIZE_W = 4;
  localparam int BLOCK_LEN  = 64;

  localparam logic [5:0] LAST_IDX = 6'(BLOCK_LEN - 1);

  localparam logic [3:0] ZRL_RUN  = 4'd15;
  localparam logic [3:0] ZRL_SIZE = 4'd0;
  localparam logic [3:0] EOB_RUN  = 4'd0;
  localparam logic [3:0] EOB_SIZE = 4'd0;

  typedef enum logic {
    S_RUN,
    S_ZRL
  } state_t;

endpackage

// File: rtl/jpeg_size_cat.sv
// Size category (significant bits of |v|) and masked one's-complement amplitude.
module jpeg_size_cat
  import jpeg_pkg::*;
#(
  parameter int COEF_W = DEF_COEF_W,
  parameter int SIZE_W = DEF_SIZE_W
) (
  input  logic signed [COEF_W-1:0] val_i,
  output logic        [SIZE_W-1:0] cat_o,
  output logic        [COEF_W-1:0] amp_o
);

  logic [COEF_W:0] ext;
  logic [COEF_W:0] mag;
  logic [COEF_W:0] ones;
  logic [COEF_W:0] mask;

  // One extra bit so the magnitude of the most negative value is representable.
  always_comb begin
    ext   = {val_i[COEF_W-1], val_i};
    mag   = val_i[COEF_W-1] ? (~ext + (COEF_W+1)'(1)) : ext;
    cat_o = '0;
    for (int i = 0; i <= COEF_W; i++) begin
      if (mag[i]) cat_o = SIZE_W'(i + 1);
    end
    ones  = ext - (COEF_W+1)'(val_i[COEF_W-1]);
    mask  = ((COEF_W+1)'(1) << cat_o) - (COEF_W+1)'(1);
    amp_o = COEF_W'(ones & mask);
  end

endmodule

// File: rtl/jpeg_rle_encoder.sv
// Zig-zag coefficient stream to JPEG symbols (DC diff, AC run/size, ZRL, EOB).
// One registered output stage; in_ready drops while ZRLs are being emitted.
module jpeg_rle_encoder
  import jpeg_pkg::*;
#(
  parameter int COEF_W = DEF_COEF_W,
  parameter int SIZE_W = DEF_SIZE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     restart,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [SIZE_W-1:0] out_run,
  output logic        [SIZE_W-1:0] out_size,
  output logic        [COEF_W-1:0] out_amp,
  output logic                     out_dc,
  output logic                     out_last
);

  state_t                    state_q;
  logic [5:0]                idx_q;
  logic [5:0]                run_q;
  logic signed [COEF_W-1:0]  pred_q;
  logic signed [COEF_W-1:0]  held_q;
  logic                      out_valid_q;
  logic [SIZE_W-1:0]         out_run_q;
  logic [SIZE_W-1:0]         out_size_q;
  logic [COEF_W-1:0]         out_amp_q;
  logic                      out_dc_q;
  logic                      out_last_q;

  logic                      out_free;
  logic                      accept;
  logic                      is_last;
  logic                      run_big;
  logic signed [COEF_W-1:0]  pred_eff;
  logic signed [COEF_W-1:0]  dc_diff;
  logic signed [COEF_W-1:0]  ac_val;
  logic [SIZE_W-1:0]         dc_cat, ac_cat;
  logic [COEF_W-1:0]         dc_amp, ac_amp;

  logic                      emit;
  logic [SIZE_W-1:0]         sym_run, sym_size;
  logic [COEF_W-1:0]         sym_amp;
  logic                      sym_dc, sym_last;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == S_RUN) && out_free;
  assign accept   = in_valid && in_ready;
  assign is_last  = (idx_q == LAST_IDX);
  assign run_big  = (run_q[5:4] != 2'b00);
  // A restart coincident with the DC accept must already see a zero predictor.
  assign pred_eff = restart ? '0 : pred_q;
  assign dc_diff  = in_coef - pred_eff;
  assign ac_val   = (state_q == S_ZRL) ? held_q : in_coef;

  jpeg_size_cat #(.COEF_W(COEF_W), .SIZE_W(SIZE_W)) u_dc_cat (
    .val_i (dc_diff),
    .cat_o (dc_cat),
    .amp_o (dc_amp)
  );

  jpeg_size_cat #(.COEF_W(COEF_W), .SIZE_W(SIZE_W)) u_ac_cat (
    .val_i (ac_val),
    .cat_o (ac_cat),
    .amp_o (ac_amp)
  );

  always_comb begin
    emit     = 1'b0;
    sym_run  = '0;
    sym_size = '0;
    sym_amp  = '0;
    sym_dc   = 1'b0;
    sym_last = 1'b0;
    if (state_q == S_ZRL) begin
      emit = out_free;
      if (run_big) begin
        sym_run  = SIZE_W'(ZRL_RUN);
        sym_size = SIZE_W'(ZRL_SIZE);
      end else begin
        sym_run  = SIZE_W'(run_q[3:0]);
        sym_size = ac_cat;
        sym_amp  = ac_amp;
        sym_last = (idx_q == '0);  // idx has already wrapped if the held coef was index 63
      end
    end else if (idx_q == '0) begin
      emit     = accept;
      sym_size = dc_cat;
      sym_amp  = dc_amp;
      sym_dc   = 1'b1;
    end else if (in_coef == '0) begin
      emit     = accept && is_last;
      sym_run  = SIZE_W'(EOB_RUN);
      sym_size = SIZE_W'(EOB_SIZE);
      sym_last = 1'b1;
    end else if (run_big) begin
      emit     = accept;
      sym_run  = SIZE_W'(ZRL_RUN);
      sym_size = SIZE_W'(ZRL_SIZE);
    end else begin
      emit     = accept;
      sym_run  = SIZE_W'(run_q[3:0]);
      sym_size = ac_cat;
      sym_amp  = ac_amp;
      sym_last = is_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      idx_q       <= '0;
      run_q       <= '0;
      pred_q      <= '0;
      held_q      <= '0;
      out_valid_q <= 1'b0;
      out_run_q   <= '0;
      out_size_q  <= '0;
      out_amp_q   <= '0;
      out_dc_q    <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (emit) begin
        out_valid_q <= 1'b1;
        out_run_q   <= sym_run;
        out_size_q  <= sym_size;
        out_amp_q   <= sym_amp;
        out_dc_q    <= sym_dc;
        out_last_q  <= sym_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (restart) pred_q <= '0;

      case (state_q)
        S_RUN: begin
          if (accept) begin
            idx_q <= idx_q + 6'd1;
            if (idx_q == '0) begin
              pred_q <= in_coef;
              run_q  <= '0;
            end else if (in_coef == '0) begin
              run_q <= is_last ? 6'd0 : run_q + 6'd1;
            end else if (run_big) begin
              // First ZRL goes out with the accept; the rest drain from S_ZRL.
              run_q   <= run_q - 6'd16;
              held_q  <= in_coef;
              state_q <= S_ZRL;
            end else begin
              run_q <= '0;
            end
          end
        end
        S_ZRL: begin
          if (out_free) begin
            if (run_big) begin
              run_q <= run_q - 6'd16;
            end else begin
              run_q   <= '0;
              state_q <= S_RUN;
            end
          end
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_run   = out_run_q;
  assign out_size  = out_size_q;
  assign out_amp   = out_amp_q;
  assign out_dc    = out_dc_q;
  assign out_last  = out_last_q;

endmodule
